// File: rtl/panda_divider_pkg.sv
// Shared definitions for the PandA pulse divider: counter width and route encoding.
package panda_divider_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ROUTE_NONE = 2'd0,
    ROUTE_D    = 2'd1,
    ROUTE_N    = 2'd2
  } route_t;

endpackage

// File: rtl/panda_divider.sv
// Pulse divider: every div_eff-th rising-edge-delimited pulse goes to outd_o, the rest to outn_o.
module panda_divider
  import panda_divider_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inp_i,
  input  logic             FIRST_PULSE,
  input  logic [CNT_W-1:0] DIVISOR,
  input  logic             FORCE_RST,
  output logic             outd_o,
  output logic             outn_o,
  output logic [CNT_W-1:0] COUNT
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  route_t           route_q, route_d;
  logic             inp_prev_q;
  logic             outd_q, outd_d;
  logic             outn_q, outn_d;

  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] preload;
  logic             rise;

  // Next-state: routing decision is made on the rising edge and held for the pulse.
  always_comb begin
    cnt_d   = cnt_q;
    route_d = route_q;
    outd_d  = 1'b0;
    outn_d  = 1'b0;

    div_m1  = (DIVISOR == CNT_W'(0)) ? CNT_W'(0) : DIVISOR - CNT_W'(1);
    preload = FIRST_PULSE ? div_m1 : CNT_W'(0);
    rise    = inp_i & ~inp_prev_q;

    if (FORCE_RST) begin
      cnt_d   = preload;
      route_d = ROUTE_NONE;
    end else begin
      if (rise) begin
        if (cnt_q >= div_m1) begin
          route_d = ROUTE_D;
          cnt_d   = CNT_W'(0);
        end else begin
          route_d = ROUTE_N;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      outd_d = inp_i & (route_d == ROUTE_D);
      outn_d = inp_i & (route_d == ROUTE_N);
    end
  end

  // State registers; inp_prev tracks inp_i through reset so a held pulse is not counted.
  always_ff @(posedge clk_i) begin
    inp_prev_q <= inp_i;
    if (rst_i) begin
      cnt_q   <= preload;
      route_q <= ROUTE_NONE;
      outd_q  <= 1'b0;
      outn_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      route_q <= route_d;
      outd_q  <= outd_d;
      outn_q  <= outn_d;
    end
  end

  assign outd_o = outd_q;
  assign outn_o = outn_q;
  assign COUNT  = cnt_q;

endmodule

// File: tb/tb_panda_divider.sv
// Self-checking bench for panda_divider: vector table, directed corner cases, random vs. model.
module tb_panda_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inp = 1'b0;
  logic        first_pulse = 1'b0;
  logic [31:0] divisor = 32'd3;
  logic        force_rst = 1'b0;
  logic        outd;
  logic        outn;
  logic [31:0] count;

  int total = 0;
  int bad   = 0;

  // Behavioural model: pulses since the last divided pulse, plus where the current pulse went.
  longint m_since;
  int     m_dest;  // 0 none, 1 divided, 2 non-divided
  bit     m_prev;
  bit     m_outd, m_outn;

  panda_divider dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .inp_i      (inp),
    .FIRST_PULSE(first_pulse),
    .DIVISOR    (divisor),
    .FORCE_RST  (force_rst),
    .outd_o     (outd),
    .outn_o     (outn),
    .COUNT      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] div;
    logic        fp;
    int          npulses;
    logic [15:0] d_mask;   // bit i set: pulse i must appear on outd
    logic [31:0] end_count;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model one clock edge from the inputs currently applied.
  task automatic model_edge();
    longint n;
    n = (divisor == 0) ? 1 : longint'(divisor);
    if (rst || force_rst) begin
      m_since = first_pulse ? n - 1 : 0;
      m_dest  = 0;
      m_outd  = 0;
      m_outn  = 0;
    end else begin
      if (inp && !m_prev) begin
        if (m_since + 1 >= n) begin
          m_dest  = 1;
          m_since = 0;
        end else begin
          m_dest  = 2;
          m_since = m_since + 1;
        end
      end
      m_outd = inp && (m_dest == 1);
      m_outn = inp && (m_dest == 2);
    end
    m_prev = inp;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    total++;
    if (outd !== m_outd || outn !== m_outn || count !== 32'(m_since)) begin
      bad++;
      $display("FAIL cycle: got outd=%b outn=%b count=%0d expected outd=%b outn=%b count=%0d at %0t",
               outd, outn, count, m_outd, m_outn, m_since, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One pulse of given width and gap; reports what the outputs showed right after the rise.
  task automatic pulse(input int width, input int gap, output logic got_d, output logic got_n);
    inp = 1'b1;
    step();
    got_d = outd;
    got_n = outn;
    for (int i = 1; i < width; i++) step();
    inp = 1'b0;
    for (int i = 0; i < gap; i++) step();
  endtask

  initial begin
    logic gd, gn;

    vecs[0] = '{div: 32'd3, fp: 1'b0, npulses: 9, d_mask: 16'b100100100, end_count: 32'd0};
    vecs[1] = '{div: 32'd3, fp: 1'b1, npulses: 4, d_mask: 16'b1001,      end_count: 32'd0};
    vecs[2] = '{div: 32'd0, fp: 1'b0, npulses: 5, d_mask: 16'b11111,     end_count: 32'd0};
    vecs[3] = '{div: 32'd1, fp: 1'b1, npulses: 4, d_mask: 16'b1111,      end_count: 32'd0};
    vecs[4] = '{div: 32'd4, fp: 1'b0, npulses: 6, d_mask: 16'b001000,    end_count: 32'd2};
    vecs[5] = '{div: 32'd2, fp: 1'b1, npulses: 5, d_mask: 16'b10101,     end_count: 32'd0};

    step();
    chk("reset_outd", outd, 0);
    chk("reset_outn", outn, 0);
    chk("reset_count", count, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      divisor     = vecs[v].div;
      first_pulse = vecs[v].fp;
      do_reset();
      chk("preload", count, (vecs[v].fp && vecs[v].div > 1) ? vecs[v].div - 1 : 0);
      for (int p = 0; p < vecs[v].npulses; p++) begin
        pulse(1 + (p % 3), 1 + (p % 2), gd, gn);
        chk($sformatf("vec%0d_p%0d_d", v, p), gd, vecs[v].d_mask[p]);
        chk($sformatf("vec%0d_p%0d_n", v, p), gn, !vecs[v].d_mask[p]);
      end
      chk($sformatf("vec%0d_end_count", v), count, vecs[v].end_count);
    end

    // FORCE_RST mid-count returns to 0 and restarts the sequence.
    divisor = 32'd4; first_pulse = 1'b0;
    do_reset();
    pulse(2, 1, gd, gn);
    pulse(2, 1, gd, gn);
    chk("frc_before", count, 2);
    force_rst = 1'b1; step(); force_rst = 1'b0;
    chk("frc_after", count, 0);
    for (int p = 0; p < 3; p++) begin
      pulse(1, 1, gd, gn);
      chk("frc_next_n", gn, 1);
      chk("frc_next_d", gd, 0);
    end

    // FORCE_RST coincident with a rising edge: that edge is discarded.
    divisor = 32'd3;
    do_reset();
    pulse(1, 1, gd, gn);
    inp = 1'b1; force_rst = 1'b1; step(); force_rst = 1'b0;
    chk("coinc_outs", {outd, outn}, 0);
    chk("coinc_count", count, 0);
    step(); step();
    chk("coinc_held", {outd, outn}, 0);
    inp = 1'b0; step();
    pulse(1, 1, gd, gn);
    chk("coinc_next_n", gn, 1);
    chk("coinc_next_cnt", count, 1);

    // Input held high through reset release is not counted.
    divisor = 32'd3; first_pulse = 1'b1;
    inp = 1'b1; rst = 1'b1; step(); step();
    rst = 1'b0; step(); step();
    chk("held_outs", {outd, outn}, 0);
    chk("held_count", count, 2);
    inp = 1'b0; step();
    pulse(1, 1, gd, gn);
    chk("held_first_d", gd, 1);
    chk("held_first_cnt", count, 0);

    // Reset mid-pulse drops the output until the next rising edge.
    first_pulse = 1'b0;
    do_reset();
    inp = 1'b1; step();
    chk("midrst_up", outn, 1);
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    chk("midrst_down", {outd, outn}, 0);
    inp = 1'b0; step();

    // Lowering DIVISOR below the count: next pulse is divided.
    divisor = 32'd5;
    do_reset();
    for (int p = 0; p < 3; p++) pulse(1, 1, gd, gn);
    chk("divchg_before", count, 3);
    divisor = 32'd2;
    pulse(1, 1, gd, gn);
    chk("divchg_d", gd, 1);
    chk("divchg_cnt", count, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      inp       = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 99) == 0);
      force_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) divisor = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) first_pulse = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; force_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
